ara_tohost_monitor: RTL and testbench
=====================================

# ara_tohost_monitor

Passive end-of-computation monitor inside the Ara test harness. It snoops the AXI write channels between the system crossbar and the DRAM model, detects writes to the `tohost` word, and drives the harness `exit_o` word that the Verilator top polls. It also measures the cycle count from reset release to exit. The block never back-pressures the bus.

## Interface
- `AxiAddrWidth`, default 64: AXI address width.
- `AxiDataWidth`, default 64: AXI data width; power of two, ≥64.
- `TohostAddr`, default 64'h8000_1000: byte address of `tohost`; 8-byte aligned.
- `AwDepth`, default 4: outstanding-AW tracking depth; power of two.
- `clk_i` in 1: clock.
- `rst_i` in 1: reset, asynchronous and active-high.
- `aw_valid_i`, `aw_ready_i` in 1: snooped AW handshake.
- `aw_addr_i` in AxiAddrWidth: AW start address.
- `aw_len_i` in 8: AXI burst length minus 1; INCR bursts only.
- `aw_size_i` in 3: log2 of bytes per beat.
- `w_valid_i`, `w_ready_i`, `w_last_i` in 1: snooped W handshake and last flag.
- `w_data_i` in AxiDataWidth: W data.
- `w_strb_i` in AxiDataWidth/8: W byte strobes.
- `exit_o` out 64: `tohost` shadow. Bit 0 = done; bits 63:1 = exit code.
- `runtime_o` out 64: cycles from reset release to done; frozen once done.
- `err_o` out 1: sticky protocol-error flag.

## Operation
- AW handshake is `aw_valid_i & aw_ready_i`. On an AW handshake, push {addr, len, size} into the tracking FIFO.
- W handshake is `w_valid_i & w_ready_i`. W beats consume the FIFO head in order. A beat counter holds the index of the current beat.
- Beat address = head.addr + beat × 2^head.size, with INCR semantics.
- A beat hits when the beat address, aligned down to 8 bytes, equals `TohostAddr`.
- On a hit, select the 64-bit lane at bit offset (TohostAddr mod (AxiDataWidth/8)) × 8. Merge only the strobed bytes of that lane into the shadow.
- On `w_last_i`: pop the FIFO and clear the beat counter. If the beat count disagrees with head.len, set `err_o`.
- FSM states:
  - RUN: reset state; runtime counter increments every cycle.
  - DONE: entered in the cycle after a hit beat leaves shadow bit 0 = 1. The counter freezes. The shadow keeps updating on further hits. DONE is left only by reset.
- Boundary conditions:
  - W handshake while the FIFO is empty: beat ignored, `err_o` set.
  - AW handshake while the FIFO is full: AW dropped, `err_o` set.
  - AW and W handshakes in the same cycle with the FIFO empty: the new AW is used for that beat (bypass).
  - Simultaneous push and pop on a full FIFO: legal; no error.
  - Runtime counter saturates at 2^64−1.

## Timing
- Reset values: `exit_o` = 0, `runtime_o` = 0, `err_o` = 0. FSM in RUN, FIFO empty, beat counter 0.
- `exit_o` is registered and updates in the cycle after the hit W handshake.
- `runtime_o` equals the number of rising edges since reset deassertion, through the hit-beat edge inclusive.
- Reset mid-burst clears all state immediately. No partial beat survives.

## Structure
- Shared package `ara_tb_pkg`: `aw_entry_t` {addr, len, size}; function `beat_addr(entry, idx)`; default `TohostAddr` constant.
- One sub-module: `ara_tohost_aw_fifo`, a parameterised FIFO of `aw_entry_t` (depth `AwDepth`) with full, empty and bypass.
- FSM, beat counter, lane merge and runtime counter live in the top module.

## Test plan
- Single beat, 64-bit bus: AW to 0x8000_1000, W data 0x1, strb 0xFF.
  - `exit_o` = 1 one cycle after the W handshake.
  - `runtime_o` frozen at that cycle count.
- Failure code, 512-bit bus (NrLanes=16): write to 0x8000_1008 with data 0x7 in lane 1.
  - `exit_o` = 0x7, i.e. exit code 3.
- Burst: AW at 0x8000_0FF0, len=3, size=3; the 3rd beat (0x8000_1000) carries 0x1.
  - Only beat 3 updates `exit_o`.
  - `err_o` stays 0.
- Partial strobe: strb 0xFE writing 0xFF..FF, then strb 0x01 writing 0x01.
  - Shadow = 0xFFFF_FFFF_FFFF_FF01 at the end.
  - DONE is entered only after the second beat.
- Errors:
  - W handshake with no AW → `err_o` = 1, `exit_o` unchanged.
  - 5 AWs outstanding with AwDepth=4 → `err_o` = 1.
- Reset mid-burst: assert `rst_i` between beats 1 and 2 → all outputs return to 0 immediately; the next clean write behaves normally.

Source files
------------

// File: rtl/ara_tb_pkg.sv
// rtl/ara_tb_pkg.sv - shared types and helpers for the tohost monitor
package ara_tb_pkg;

  localparam logic [63:0] DefaultTohostAddr = 64'h8000_1000;

  typedef struct packed {
    logic [63:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
  } aw_entry_t;

  typedef enum logic {ST_RUN, ST_DONE} mon_state_e;

  // INCR burst: every beat advances by one full beat of 2^size bytes
  function automatic logic [63:0] beat_addr(aw_entry_t entry, logic [7:0] idx);
    return entry.addr + (64'(idx) << entry.size);
  endfunction

endpackage

// File: rtl/ara_tohost_aw_fifo.sv
// rtl/ara_tohost_aw_fifo.sv - outstanding AW tracker with same-cycle bypass when empty
module ara_tohost_aw_fifo
  import ara_tb_pkg::*;
#(
  parameter int unsigned Depth = 4
) (
  input  logic      clk_i,
  input  logic      rst_i,
  input  logic      push_i,
  input  aw_entry_t entry_i,
  input  logic      pop_i,
  output aw_entry_t head_o,
  output logic      head_valid_o,
  output logic      full_o,
  output logic      empty_o,
  output logic      drop_o
);

  localparam int unsigned PtrW = $clog2(Depth);

  aw_entry_t       mem_q [Depth];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]   count_q;
  logic            bypass, do_push, do_pop;

  assign empty_o      = (count_q == '0);
  assign full_o       = (count_q == (PtrW+1)'(Depth));
  assign bypass       = empty_o & push_i & pop_i;
  assign do_pop       = pop_i & ~empty_o;
  assign do_push      = push_i & ~bypass & (~full_o | pop_i);
  assign drop_o       = push_i & full_o & ~pop_i;
  assign head_valid_o = ~empty_o | push_i;
  assign head_o       = empty_o ? entry_i : mem_q[rd_ptr_q];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (do_push & ~do_pop)      count_q <= count_q + 1'b1;
      else if (do_pop & ~do_push) count_q <= count_q - 1'b1;
    end
  end

  // Storage needs no reset: count_q gates every read
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= entry_i;
  end

endmodule

// File: rtl/ara_tohost_monitor.sv
// rtl/ara_tohost_monitor.sv - snoops AXI writes to tohost, exposes exit word and runtime
module ara_tohost_monitor
  import ara_tb_pkg::*;
#(
  parameter int unsigned AxiAddrWidth = 64,
  parameter int unsigned AxiDataWidth = 64,
  parameter logic [63:0] TohostAddr   = DefaultTohostAddr,
  parameter int unsigned AwDepth      = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      aw_valid_i,
  input  logic                      aw_ready_i,
  input  logic [AxiAddrWidth-1:0]   aw_addr_i,
  input  logic [7:0]                aw_len_i,
  input  logic [2:0]                aw_size_i,
  input  logic                      w_valid_i,
  input  logic                      w_ready_i,
  input  logic                      w_last_i,
  input  logic [AxiDataWidth-1:0]   w_data_i,
  input  logic [AxiDataWidth/8-1:0] w_strb_i,
  output logic [63:0]               exit_o,
  output logic [63:0]               runtime_o,
  output logic                      err_o
);

  localparam int unsigned StrbW    = AxiDataWidth / 8;
  localparam int unsigned LaneByte = 32'(TohostAddr & 64'(StrbW - 1));

  logic        aw_hs, w_hs, head_valid, fifo_full, fifo_empty, fifo_drop, beat_ok, hit;
  aw_entry_t   aw_entry, head;
  logic [7:0]  beat_q, lane_strb;
  logic [63:0] shadow_q, shadow_d, runtime_q, lane_data, cur_addr;
  logic        err_q, err_d;
  mon_state_e  state_q, state_d;
  logic        unused_bits;

  assign aw_hs    = aw_valid_i & aw_ready_i;
  assign w_hs     = w_valid_i & w_ready_i;
  assign aw_entry = '{addr: 64'(aw_addr_i), len: aw_len_i, size: aw_size_i};

  ara_tohost_aw_fifo #(.Depth(AwDepth)) u_aw_fifo (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .push_i       (aw_hs),
    .entry_i      (aw_entry),
    .pop_i        (w_hs & w_last_i),
    .head_o       (head),
    .head_valid_o (head_valid),
    .full_o       (fifo_full),
    .empty_o      (fifo_empty),
    .drop_o       (fifo_drop)
  );

  assign beat_ok   = w_hs & head_valid;
  assign cur_addr  = beat_addr(head, beat_q);
  assign hit       = beat_ok & ({cur_addr[63:3], 3'b000} == TohostAddr);
  assign lane_data = w_data_i[LaneByte*8 +: 64];
  assign lane_strb = w_strb_i[LaneByte +: 8];

  assign unused_bits = ^{w_data_i, w_strb_i, cur_addr[2:0], fifo_full, fifo_empty};

  always_comb begin
    shadow_d = shadow_q;
    state_d  = state_q;
    err_d    = err_q | fifo_drop | (w_hs & ~head_valid)
             | (beat_ok & w_last_i & (beat_q != head.len));
    if (hit) begin
      for (int i = 0; i < 8; i++) begin
        if (lane_strb[i]) shadow_d[8*i +: 8] = lane_data[8*i +: 8];
      end
    end
    // DONE is terminal; only reset brings the monitor back to RUN
    if (state_q == ST_RUN && hit && shadow_d[0]) state_d = ST_DONE;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_RUN;
      shadow_q  <= '0;
      err_q     <= 1'b0;
      beat_q    <= '0;
      runtime_q <= '0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      err_q    <= err_d;
      if (beat_ok) beat_q <= w_last_i ? 8'd0 : beat_q + 8'd1;
      if (state_q == ST_RUN && runtime_q != '1) runtime_q <= runtime_q + 64'd1;
    end
  end

  assign exit_o    = shadow_q;
  assign runtime_o = runtime_q;
  assign err_o     = err_q;

endmodule

// File: tb/tb_ara_tohost_monitor.sv
// tb/tb_ara_tohost_monitor.sv - directed bench with a queue-based reference model
module tb_ara_tohost_monitor;

  localparam logic [63:0] TOHOST = 64'h8000_1000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        aw_valid, w_valid, w_last;
  logic [63:0] aw_addr;
  logic [7:0]  aw_len;
  logic [2:0]  aw_size;
  logic [63:0] w_data;
  logic [7:0]  w_strb;
  logic [63:0] exit_a, runtime_a;
  logic        err_a;

  logic         b_valid;
  logic [511:0] b_data;
  logic [63:0]  b_strb;
  logic [63:0]  exit_b, runtime_b;
  logic         err_b;

  ara_tohost_monitor u_dut (
    .clk_i(clk), .rst_i(rst),
    .aw_valid_i(aw_valid), .aw_ready_i(1'b1), .aw_addr_i(aw_addr),
    .aw_len_i(aw_len), .aw_size_i(aw_size),
    .w_valid_i(w_valid), .w_ready_i(1'b1), .w_last_i(w_last),
    .w_data_i(w_data), .w_strb_i(w_strb),
    .exit_o(exit_a), .runtime_o(runtime_a), .err_o(err_a)
  );

  ara_tohost_monitor #(.AxiDataWidth(512), .TohostAddr(64'h8000_1008)) u_dut_wide (
    .clk_i(clk), .rst_i(rst),
    .aw_valid_i(b_valid), .aw_ready_i(1'b1), .aw_addr_i(64'h8000_1008),
    .aw_len_i(8'd0), .aw_size_i(3'd3),
    .w_valid_i(b_valid), .w_ready_i(1'b1), .w_last_i(1'b1),
    .w_data_i(b_data), .w_strb_i(b_strb),
    .exit_o(exit_b), .runtime_o(runtime_b), .err_o(err_b)
  );

  int n_pass = 0;
  int n_total = 0;
  bit mon_on = 1'b0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  typedef struct {
    logic [63:0] addr;
    int          len;
    int          size;
  } aw_t;

  aw_t         mq[$];
  int          m_beat;
  logic [63:0] m_exit, m_rt;
  bit          m_err, m_done;

  task automatic model_reset();
    mq.delete();
    m_beat = 0; m_exit = '0; m_rt = '0; m_err = 1'b0; m_done = 1'b0;
  endtask

  task automatic model_edge();
    aw_t e;
    logic [63:0] a;
    if (rst) begin
      model_reset();
      return;
    end
    if (!m_done) m_rt++;
    if (aw_valid) begin
      if (mq.size() >= 4 && !(w_valid && w_last)) m_err = 1'b1;
      else begin
        e.addr = aw_addr; e.len = int'(aw_len); e.size = int'(aw_size);
        mq.push_back(e);
      end
    end
    if (w_valid) begin
      if (mq.size() == 0) m_err = 1'b1;
      else begin
        e = mq[0];
        a = e.addr + m_beat * (64'd1 << e.size);
        if (a / 8 * 8 == TOHOST) begin
          for (int i = 0; i < 8; i++)
            if (w_strb[i]) m_exit[8*i +: 8] = w_data[8*i +: 8];
          if (m_exit[0]) m_done = 1'b1;
        end
        if (w_last) begin
          if (m_beat != e.len) m_err = 1'b1;
          void'(mq.pop_front());
          m_beat = 0;
        end else m_beat++;
      end
    end
  endtask

  always @(negedge clk) begin
    if (mon_on) begin
      chk("model_exit", exit_a, m_exit);
      chk("model_runtime", runtime_a, m_rt);
      chk("model_err", 64'(err_a), 64'(m_err));
    end
  end

  task automatic cyc();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle();
    aw_valid = 1'b0; aw_addr = '0; aw_len = '0; aw_size = 3'd3;
    w_valid = 1'b0; w_last = 1'b0; w_data = '0; w_strb = '0;
    b_valid = 1'b0; b_data = '0; b_strb = '0;
  endtask

  task automatic drive(bit awv, logic [63:0] addr, logic [7:0] len,
                       bit wv, logic [63:0] data, logic [7:0] strb, bit last);
    aw_valid = awv; aw_addr = addr; aw_len = len; aw_size = 3'd3;
    w_valid = wv; w_data = data; w_strb = strb; w_last = last;
    cyc();
    idle();
  endtask

  task automatic do_reset();
    #1;
    rst = 1'b1;
    model_reset();
    idle();
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    model_reset();
    cyc();
    cyc();
    chk("reset_exit", exit_a, 64'd0);
    chk("reset_runtime", runtime_a, 64'd0);
    chk("reset_err", 64'(err_a), 64'd0);
    chk("reset_exit_wide", exit_b, 64'd0);
    mon_on = 1'b1;
    rst = 1'b0;

    // single beat: edges 1-3 idle, edge 4 AW, edge 5 hit
    cyc(); cyc(); cyc();
    drive(1, TOHOST, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 64'h1, 8'hFF, 1);
    chk("single_exit", exit_a, 64'd1);
    chk("single_runtime", runtime_a, 64'd5);
    cyc(); cyc(); cyc();
    chk("single_frozen", runtime_a, 64'd5);

    // wide bus, tohost in lane 1, AW and W in the same cycle
    b_valid = 1'b1;
    b_data = 512'h7 << 64;
    b_strb = 64'hFF << 8;
    cyc();
    idle();
    chk("wide_exit", exit_b, 64'h7);
    chk("wide_code", exit_b >> 1, 64'd3);
    chk("wide_err", 64'(err_b), 64'd0);

    // four-beat burst, third beat is tohost
    do_reset();
    drive(1, 64'h8000_0FF0, 3, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 64'hDEAD, 8'hFF, 0);
    drive(0, 0, 0, 1, 64'hBEEF, 8'hFF, 0);
    chk("burst_before", exit_a, 64'd0);
    drive(0, 0, 0, 1, 64'h1, 8'hFF, 0);
    chk("burst_hit", exit_a, 64'd1);
    drive(0, 0, 0, 1, 64'h55, 8'hFF, 1);
    chk("burst_after", exit_a, 64'd1);
    chk("burst_err", 64'(err_a), 64'd0);

    // partial strobes
    do_reset();
    drive(1, TOHOST, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 1, '1, 8'hFE, 1);
    chk("partial_first", exit_a, 64'hFFFF_FFFF_FFFF_FF00);
    drive(1, TOHOST, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 64'h1, 8'h01, 1);
    chk("partial_final", exit_a, 64'hFFFF_FFFF_FFFF_FF01);

    // bypass: AW and W together on an empty tracker
    do_reset();
    drive(1, TOHOST, 0, 1, 64'h9, 8'hFF, 1);
    chk("bypass_exit", exit_a, 64'h9);
    chk("bypass_err", 64'(err_a), 64'd0);

    // W with no AW
    do_reset();
    drive(0, 0, 0, 1, 64'h1, 8'hFF, 1);
    chk("orphan_err", 64'(err_a), 64'd1);
    chk("orphan_exit", exit_a, 64'd0);

    // overflow on the fifth outstanding AW
    do_reset();
    for (int i = 0; i < 4; i++) drive(1, 64'h2000, 0, 0, 0, 0, 0);
    chk("full_no_err", 64'(err_a), 64'd0);
    drive(1, 64'h2000, 0, 0, 0, 0, 0);
    chk("overflow_err", 64'(err_a), 64'd1);

    // push and pop together on a full tracker
    do_reset();
    for (int i = 0; i < 4; i++) drive(1, 64'h2000, 0, 0, 0, 0, 0);
    drive(1, TOHOST, 0, 1, 64'h20, 8'hFF, 1);
    chk("fullpp_err", 64'(err_a), 64'd0);
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 1, 64'h0, 8'hFF, 1);
    drive(0, 0, 0, 1, 64'h5, 8'hFF, 1);
    chk("fullpp_exit", exit_a, 64'h5);
    chk("fullpp_err_end", 64'(err_a), 64'd0);

    // reset between beats of a burst
    do_reset();
    drive(1, 64'h8000_0FE0, 3, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 64'hAA, 8'hFF, 0);
    #1;
    rst = 1'b1;
    model_reset();
    #1;
    chk("midrst_exit", exit_a, 64'd0);
    chk("midrst_runtime", runtime_a, 64'd0);
    chk("midrst_err", 64'(err_a), 64'd0);
    cyc();
    rst = 1'b0;
    drive(1, TOHOST, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 64'h3, 8'hFF, 1);
    chk("midrst_clean_exit", exit_a, 64'h3);
    chk("midrst_clean_err", 64'(err_a), 64'd0);

    cyc();
    mon_on = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
